// File: rtl/cache_miss_ctrl_if.sv
// cache_miss_ctrl_if
// Bundles the handshake and data buses of the non-blocking cache miss controller.
//   upstream   : uvld_i/urdy_o beat with hit_i, we_i, flush_i, addr_i, plru_i
//   memory     : qvld_o/qrdy_i beat carrying qdat_o = {flush, way one-hot, id, addr}
//   completion : ack_i strobe with ack_id_i and ack_dat_i
//   downstream : dvld_o/drdy_i beat carrying ddat_o and daddr_o
//   status     : err_o sticky protocol error
// The slave modport is the controller; the master modport is its surroundings.
interface cache_miss_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_MSHR   = 4
);
  localparam int ID_W   = $clog2(NUM_MSHR);
  localparam int QDAT_W = 1 + NUM_WAYS + ID_W + ADDR_WIDTH;

  logic                  uvld_i;
  logic                  urdy_o;
  logic                  hit_i;
  logic                  we_i;
  logic                  flush_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [NUM_WAYS-2:0]   plru_i;

  logic                  qvld_o;
  logic                  qrdy_i;
  logic [QDAT_W-1:0]     qdat_o;

  logic                  ack_i;
  logic [ID_W-1:0]       ack_id_i;
  logic [DATA_WIDTH-1:0] ack_dat_i;

  logic                  dvld_o;
  logic                  drdy_i;
  logic [DATA_WIDTH-1:0] ddat_o;
  logic [ADDR_WIDTH-1:0] daddr_o;

  logic                  err_o;

  modport master (
    output uvld_i, hit_i, we_i, flush_i, addr_i, plru_i,
    output qrdy_i,
    output ack_i, ack_id_i, ack_dat_i,
    output drdy_i,
    input  urdy_o, qvld_o, qdat_o, dvld_o, ddat_o, daddr_o, err_o
  );

  modport slave (
    input  uvld_i, hit_i, we_i, flush_i, addr_i, plru_i,
    input  qrdy_i,
    input  ack_i, ack_id_i, ack_dat_i,
    input  drdy_i,
    output urdy_o, qvld_o, qdat_o, dvld_o, ddat_o, daddr_o, err_o
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl
// Non-blocking miss controller holding up to NUM_MSHR outstanding line misses in
// a ring. Misses are allocated at the tail, issued to memory in allocation order,
// completed by out-of-order ID-tagged acks and retired from the head in
// allocation order. Flush entries retire silently once acked.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; discards all entries
//   bus   : cache_miss_ctrl_if slave modport (upstream, memory, ack, downstream, err)
module cache_miss_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_MSHR   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_miss_ctrl_if.slave     bus
);
  localparam int ID_W  = $clog2(NUM_MSHR);
  localparam int WAY_W = $clog2(NUM_WAYS);

  localparam logic [ID_W:0]         FULL_COUNT = (ID_W+1)'(NUM_MSHR);
  localparam logic [WAY_W:0]        LEAF_BASE  = (WAY_W+1)'(NUM_WAYS - 1);
  localparam logic [NUM_WAYS-1:0]   WAY0_HOT   = NUM_WAYS'(1);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_PEND,
    ST_WAIT,
    ST_DONE
  } entry_state_t;

  entry_state_t          state_q [NUM_MSHR];
  entry_state_t          state_d [NUM_MSHR];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_MSHR];
  logic                  flush_q [NUM_MSHR];
  logic [NUM_WAYS-1:0]   way_q   [NUM_MSHR];
  logic [DATA_WIDTH-1:0] data_q  [NUM_MSHR];

  logic [ID_W-1:0] tail_q;
  logic [ID_W-1:0] issue_q;
  logic [ID_W-1:0] head_q;
  logic [ID_W:0]   count_q;
  logic            err_q;

  logic urdy;
  logic alloc;
  logic qvld;
  logic issue;
  logic ack_ok;
  logic ack_bad;
  logic head_done;
  logic dvld;
  logic retire;

  logic [2*NUM_WAYS-1:0] plru_ext;
  logic [WAY_W:0]        node;
  logic [WAY_W:0]        leaf;
  logic [NUM_WAYS-1:0]   victim;

  // Ready depends only on registered occupancy, so a retire in the same cycle
  // never opens a slot early.
  assign urdy  = (count_q < FULL_COUNT);
  assign alloc = bus.uvld_i & urdy & ~bus.hit_i & ~bus.we_i;

  assign qvld  = (state_q[issue_q] == ST_PEND);
  assign issue = qvld & bus.qrdy_i;

  assign ack_ok  = bus.ack_i & (state_q[bus.ack_id_i] == ST_WAIT);
  assign ack_bad = bus.ack_i & (state_q[bus.ack_id_i] != ST_WAIT);

  // Flush entries have no downstream consumer, so they leave without a beat.
  assign head_done = (state_q[head_q] == ST_DONE);
  assign dvld      = head_done & ~flush_q[head_q];
  assign retire    = head_done & (flush_q[head_q] | bus.drdy_i);

  // The PLRU vector is zero-extended so the node index width matches the
  // vector exactly; only internal nodes are ever looked up.
  assign plru_ext = {{(NUM_WAYS+1){1'b0}}, bus.plru_i};

  // Tree walk: a 0 bit goes to child 2n+1, a 1 bit to child 2n+2. After
  // WAY_W levels the node sits in the leaf row, offset by NUM_WAYS-1.
  always_comb begin
    node = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      node = (node << 1) + {{WAY_W{1'b0}}, 1'b1} + {{WAY_W{1'b0}}, plru_ext[node]};
    end
    leaf   = node - LEAF_BASE;
    victim = WAY0_HOT << leaf[WAY_W-1:0];
  end

  // Entry lifecycle. The four transitions can never target the same entry in
  // one cycle: alloc needs FREE, issue PEND, ack WAIT and retire DONE.
  always_comb begin
    state_d = state_q;
    if (alloc)  state_d[tail_q]         = ST_PEND;
    if (issue)  state_d[issue_q]        = ST_WAIT;
    if (ack_ok) state_d[bus.ack_id_i]   = ST_DONE;
    if (retire) state_d[head_q]         = ST_FREE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i] <= ST_FREE;
      end
    end else begin
      state_q <= state_d;
    end
  end

  // Entry payload, ring pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        addr_q[i]  <= '0;
        flush_q[i] <= 1'b0;
        way_q[i]   <= '0;
        data_q[i]  <= '0;
      end
      tail_q  <= '0;
      issue_q <= '0;
      head_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (alloc) begin
        addr_q[tail_q]  <= bus.addr_i;
        flush_q[tail_q] <= bus.flush_i;
        way_q[tail_q]   <= victim;
        tail_q          <= tail_q + 1'b1;
      end
      if (issue) begin
        issue_q <= issue_q + 1'b1;
      end
      if (ack_ok) begin
        data_q[bus.ack_id_i] <= bus.ack_dat_i;
      end
      if (retire) begin
        head_q <= head_q + 1'b1;
      end
      if (ack_bad) begin
        err_q <= 1'b1;
      end
      count_q <= count_q + (ID_W+1)'(alloc) - (ID_W+1)'(retire);
    end
  end

  assign bus.urdy_o  = urdy;
  assign bus.qvld_o  = qvld;
  assign bus.qdat_o  = {flush_q[issue_q], way_q[issue_q], issue_q, addr_q[issue_q]};
  assign bus.dvld_o  = dvld;
  assign bus.ddat_o  = data_q[head_q];
  assign bus.daddr_o = addr_q[head_q];
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl
// Self-checking bench for cache_miss_ctrl. A queue-based reference model tracks
// misses in allocation order and predicts every output each cycle; directed
// scenarios add checks against hand-computed constants.
module tb_cache_miss_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WAYS(NW), .NUM_MSHR(NM)) bus ();

  cache_miss_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WAYS(NW), .NUM_MSHR(NM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic        flush;
    logic [3:0]  way;
    logic        issued;
    logic        acked;
    logic [31:0] data;
  } rec_t;

  rec_t        mq[$];
  logic [1:0]  m_tail = 2'd0;
  logic        m_err  = 1'b0;
  logic [31:0] returned[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // The victim is the leaf reached by choosing a half with plru[0], then a
  // quarter with the bit of the chosen half's node.
  function automatic logic [3:0] model_way(input logic [2:0] p);
    int upper;
    int sub;
    upper = int'(p[0]);
    sub   = upper != 0 ? int'(p[2]) : int'(p[1]);
    return 4'b0001 << (2 * upper + sub);
  endfunction

  // Compare DUT outputs with the model, then advance the model across the
  // coming clock edge using the inputs currently applied.
  task automatic model_step();
    int   iss;
    int   ack_idx;
    logic exp_dvld;
    logic full_before;
    logic ret;
    rec_t r;
    if (reset) begin
      mq.delete();
      m_tail = 2'd0;
      m_err  = 1'b0;
      return;
    end
    iss = -1;
    foreach (mq[i]) if (!mq[i].issued && iss < 0) iss = i;
    exp_dvld = (mq.size() > 0) && mq[0].acked && !mq[0].flush;

    checkOutput("urdy", 64'(bus.urdy_o), 64'(mq.size() < NM));
    checkOutput("qvld", 64'(bus.qvld_o), 64'(iss >= 0));
    if (iss >= 0)
      checkOutput("qdat", 64'(bus.qdat_o), 64'({mq[iss].flush, mq[iss].way, mq[iss].id, mq[iss].addr}));
    checkOutput("dvld", 64'(bus.dvld_o), 64'(exp_dvld));
    if (exp_dvld) begin
      checkOutput("ddat", 64'(bus.ddat_o), 64'(mq[0].data));
      checkOutput("daddr", 64'(bus.daddr_o), 64'(mq[0].addr));
    end
    checkOutput("err", 64'(bus.err_o), 64'(m_err));
    if (bus.dvld_o === 1'b1 && bus.drdy_i) returned.push_back(bus.daddr_o);

    full_before = (mq.size() >= NM);
    ret = (mq.size() > 0) && mq[0].acked && (mq[0].flush || bus.drdy_i);
    if (bus.ack_i) begin
      ack_idx = -1;
      foreach (mq[i]) if (mq[i].id == bus.ack_id_i && mq[i].issued && !mq[i].acked) ack_idx = i;
      if (ack_idx >= 0) begin
        mq[ack_idx].acked = 1'b1;
        mq[ack_idx].data  = bus.ack_dat_i;
      end else begin
        m_err = 1'b1;
      end
    end
    if (iss >= 0 && bus.qrdy_i) mq[iss].issued = 1'b1;
    if (ret) void'(mq.pop_front());
    if (bus.uvld_i && !full_before && !bus.hit_i && !bus.we_i) begin
      r.id     = m_tail;
      r.addr   = bus.addr_i;
      r.flush  = bus.flush_i;
      r.way    = model_way(bus.plru_i);
      r.issued = 1'b0;
      r.acked  = 1'b0;
      r.data   = '0;
      mq.push_back(r);
      m_tail = m_tail + 2'd1;
    end
  endtask

  task automatic applyStimulus(input logic uvld, input logic hit, input logic we, input logic flush,
                               input logic [31:0] addr, input logic [2:0] plru, input logic qrdy,
                               input logic ack, input logic [1:0] ack_id, input logic [31:0] ack_dat,
                               input logic drdy);
    bus.uvld_i    = uvld;
    bus.hit_i     = hit;
    bus.we_i      = we;
    bus.flush_i   = flush;
    bus.addr_i    = addr;
    bus.plru_i    = plru;
    bus.qrdy_i    = qrdy;
    bus.ack_i     = ack;
    bus.ack_id_i  = ack_id;
    bus.ack_dat_i = ack_dat;
    bus.drdy_i    = drdy;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic qrdy, input logic drdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, qrdy, 1'b0, 2'd0, 32'h0, drdy);
  endtask

  task automatic miss(input logic [31:0] addr, input logic [2:0] plru, input logic flush,
                      input logic qrdy, input logic drdy);
    applyStimulus(1'b1, 1'b0, 1'b0, flush, addr, plru, qrdy, 1'b0, 2'd0, 32'h0, drdy);
  endtask

  task automatic ack(input logic [1:0] id, input logic [31:0] dat, input logic qrdy, input logic drdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, qrdy, 1'b1, id, dat, drdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic pick_waiting(output logic found, output logic [1:0] id);
    int cand[$];
    found = 1'b0;
    id    = 2'd0;
    foreach (mq[i]) if (mq[i].issued && !mq[i].acked) cand.push_back(i);
    if (cand.size() > 0) begin
      found = 1'b1;
      id    = mq[cand[$urandom_range(cand.size() - 1)]].id;
    end
  endtask

  // Issues, acks and retires everything outstanding; bounded so it always ends.
  task automatic drain();
    logic       f;
    logic [1:0] id;
    for (int c = 0; c < 80; c++) begin
      if (mq.size() == 0) break;
      pick_waiting(f, id);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, f, id, $urandom, 1'b1);
    end
  endtask

  task automatic run_random(input int cycles);
    logic       f;
    logic [1:0] id;
    for (int c = 0; c < cycles; c++) begin
      pick_waiting(f, id);
      applyStimulus(($urandom % 2) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
                    ($urandom % 5) == 0, $urandom, 3'($urandom), ($urandom % 4) != 0,
                    f && (($urandom % 2) == 0), id, $urandom, ($urandom % 4) != 0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  id_a, id_b, id_c, id_d;
    logic [1:0]  exp_id;
    logic [31:0] addr_abcd [4];

    idle(1'b0, 1'b0);
    do_reset();
    checkOutput("rst_urdy", 64'(bus.urdy_o), 64'd1);
    checkOutput("rst_qvld", 64'(bus.qvld_o), 64'd0);
    checkOutput("rst_dvld", 64'(bus.dvld_o), 64'd0);
    checkOutput("rst_err", 64'(bus.err_o), 64'd0);
    checkOutput("rst_qdat", 64'(bus.qdat_o), 64'd0);
    checkOutput("rst_ddat", 64'(bus.ddat_o), 64'd0);
    checkOutput("rst_daddr", 64'(bus.daddr_o), 64'd0);

    $display("[TB] single miss with fill return");
    miss(32'h1000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_qvld", 64'(bus.qvld_o), 64'd1);
    checkOutput("t1_qdat", 64'(bus.qdat_o), 64'({1'b0, 4'b0001, 2'd0, 32'h1000}));
    idle(1'b1, 1'b0);
    ack(2'd0, 32'hCAFE, 1'b1, 1'b0);
    checkOutput("t1_dvld", 64'(bus.dvld_o), 64'd1);
    checkOutput("t1_ddat", 64'(bus.ddat_o), 64'h0000CAFE);
    checkOutput("t1_daddr", 64'(bus.daddr_o), 64'h1000);
    idle(1'b1, 1'b1);
    checkOutput("t1_dvld_after", 64'(bus.dvld_o), 64'd0);

    $display("[TB] victim selection");
    miss(32'h2000, 3'b101, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_way101", 64'(bus.qdat_o[37:34]), 64'(4'b1000));
    miss(32'h2100, 3'b010, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_way010", 64'(bus.qdat_o[37:34]), 64'(4'b0010));
    drain();

    $display("[TB] out-of-order acks, in-order return");
    returned.delete();
    addr_abcd[0] = 32'hA000; addr_abcd[1] = 32'hB000;
    addr_abcd[2] = 32'hC000; addr_abcd[3] = 32'hD000;
    for (int i = 0; i < 4; i++) miss(addr_abcd[i], 3'($urandom), 1'b0, 1'b1, 1'b1);
    checkOutput("t3_urdy_full", 64'(bus.urdy_o), 64'd0);
    id_a = mq[0].id; id_b = mq[1].id; id_c = mq[2].id; id_d = mq[3].id;
    idle(1'b1, 1'b1);
    ack(id_d, 32'hD0D0, 1'b1, 1'b1);
    ack(id_b, 32'hB0B0, 1'b1, 1'b1);
    ack(id_a, 32'hA0A0, 1'b1, 1'b1);
    checkOutput("t3_dvld_a", 64'(bus.dvld_o), 64'd1);
    checkOutput("t3_ddat_a", 64'(bus.ddat_o), 64'hA0A0);
    checkOutput("t3_urdy_retire_cycle", 64'(bus.urdy_o), 64'd0);
    idle(1'b1, 1'b1);
    checkOutput("t3_urdy_after_retire", 64'(bus.urdy_o), 64'd1);
    ack(id_c, 32'hC0C0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
    checkOutput("t3_return_count", 64'(returned.size()), 64'd4);
    for (int i = 0; i < 4 && i < returned.size(); i++)
      checkOutput($sformatf("t3_return_%0d", i), 64'(returned[i]), 64'(addr_abcd[i]));

    $display("[TB] flush miss then normal miss");
    returned.delete();
    miss(32'h4000, 3'b011, 1'b1, 1'b1, 1'b1);
    miss(32'h4100, 3'b100, 1'b0, 1'b1, 1'b1);
    drain();
    checkOutput("t4_return_count", 64'(returned.size()), 64'd1);
    if (returned.size() > 0) checkOutput("t4_return_addr", 64'(returned[0]), 64'h4100);

    $display("[TB] memory backpressure and spurious ack");
    exp_id = m_tail;
    miss(32'h5000, 3'b110, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0, 1'b1);
      checkOutput("t5_qvld_hold", 64'(bus.qvld_o), 64'd1);
      checkOutput("t5_qdat_hold", 64'(bus.qdat_o), 64'({1'b0, 4'b0010, exp_id, 32'h5000}));
    end
    drain();
    ack(2'd2, 32'hDEAD, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_err_sticky", 64'(bus.err_o), 64'd1);
      checkOutput("t5_urdy", 64'(bus.urdy_o), 64'd1);
      checkOutput("t5_qvld", 64'(bus.qvld_o), 64'd0);
      checkOutput("t5_dvld", 64'(bus.dvld_o), 64'd0);
      idle(1'b1, 1'b1);
    end

    $display("[TB] reset with entries in flight");
    do_reset();
    for (int i = 0; i < 3; i++) miss(32'h6000 + 32'(i * 'h40), 3'($urandom), 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    reset = 1'b1;
    idle(1'b1, 1'b0);
    reset = 1'b0;
    checkOutput("t6_urdy", 64'(bus.urdy_o), 64'd1);
    checkOutput("t6_qvld", 64'(bus.qvld_o), 64'd0);
    checkOutput("t6_dvld", 64'(bus.dvld_o), 64'd0);
    checkOutput("t6_err", 64'(bus.err_o), 64'd0);
    ack(2'd0, 32'h1234, 1'b1, 1'b1);
    checkOutput("t6_err_late_ack", 64'(bus.err_o), 64'd1);

    $display("[TB] randomized traffic");
    do_reset();
    run_random(600);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Non-blocking cache miss controller: accepts up to NUM_MSHR outstanding line misses from the cache pipeline and selects each victim way from a tree pseudo-LRU word. It issues fill/flush requests in allocation order to the async memory queue and accepts out-of-order, ID-tagged acknowledgements. It returns fill data to the downstream pipeline strictly in allocation order. It sits between the tag-compare stage and the memory-side async queue, and replaces the single-outstanding miss FSM.

## Interface
- ADDR_WIDTH, 32, request/line address width
- DATA_WIDTH, 32, fill data width
- NUM_WAYS, 4, associativity; power of 2, >=2
- NUM_MSHR, 4, outstanding-miss entries; power of 2, >=2; ID_W = $clog2(NUM_MSHR)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- uvld_i / urdy_o  in/out  1  upstream handshake
- hit_i, we_i, flush_i  in  1 each  request attributes
- addr_i  in  ADDR_WIDTH  request address
- plru_i  in  NUM_WAYS-1  tree-PLRU bits of the indexed set
- qvld_o / qrdy_i  out/in  1  memory-request handshake
- qdat_o  out  1+NUM_WAYS+ID_W+ADDR_WIDTH  packed {flush, way one-hot, id, addr}, MSB first
- ack_i  in  1  completion strobe
- ack_id_i  in  ID_W  completing entry
- ack_dat_i  in  DATA_WIDTH  fill data
- dvld_o / drdy_i  out/in  1  downstream handshake
- ddat_o  out  DATA_WIDTH  fill data
- daddr_o  out  ADDR_WIDTH  address of returned fill
- err_o  out  1  sticky protocol error

## Operation
- Entries form a ring: alloc pointer (tail), issue pointer, retire pointer (head). All are ID_W bits and wrap modulo NUM_MSHR. The occupancy count is ID_W+1 bits.
- Entry states: FREE -> PEND -> WAIT -> DONE -> FREE. Each entry holds addr, flush, way, and data.
- ubeat = uvld_i & urdy_o. A miss beat is ubeat & !hit_i & !we_i. It allocates the tail entry as PEND, latches addr_i, flush_i and the victim way, then advances tail.
- Hit and write beats are consumed with no allocation and no output.
- urdy_o = (count < NUM_MSHR). It depends only on registered state. A retire in the same cycle does not raise urdy_o.
- Victim selection: walk from node 0. Bit 0 of a node selects child 2n+1 (lower half), bit 1 selects child 2n+2 (upper half). The leaf index gives the way, encoded one-hot.
- Issue: qvld_o = (state[issue] == PEND). qdat_o is taken from that entry with id = issue. A qbeat moves the entry to WAIT and advances issue.
- Ack: if state[ack_id_i] == WAIT, latch ack_dat_i and move to DONE. Otherwise ignore the ack and set err_o.
- Retire: when state[head] == DONE:
  - flush=0: dvld_o=1, ddat_o and daddr_o come from head; a dbeat frees the entry and advances head.
  - flush=1: no downstream beat; the entry frees that cycle and head advances.
- Simultaneous allocate and retire: count is unchanged, and both pointers advance.

## Timing
- Reset values: urdy_o=1, qvld_o=0, dvld_o=0, err_o=0, qdat_o/ddat_o/daddr_o=0. All entries are FREE with zeroed fields; pointers and count are 0.
- A miss beat in cycle t gives qvld_o=1 in cycle t+1.
- An accepted ack in cycle t makes the entry DONE in t+1. dvld_o rises in t+1 if that entry is head.
- Issue order and return order both equal allocation order. Ack order is unconstrained.
- qvld_o and dvld_o stay high, with qdat_o/ddat_o/daddr_o stable, until the beat completes.
- Reset asserted mid-operation discards all entries on the next edge.
- When the ring is full, urdy_o=0. An ack to an entry that is FREE, PEND or DONE sets err_o and changes no state.

## Test plan
- Miss at addr 0x1000 with plru_i=3'b000 and NUM_WAYS=4 -> qdat_o = {0, 4'b0001, id 0, 0x1000} one cycle later. After ack id 0 with data 0xCAFE: dvld_o with ddat_o=0xCAFE and daddr_o=0x1000.
- plru_i=3'b101 -> way one-hot 4'b1000. plru_i=3'b010 -> 4'b0010.
- Four misses A–D, acks in order D,B,A,C -> downstream returns A,B,C,D. urdy_o=0 after the fourth miss and returns to 1 the cycle after the first retire.
- Flush miss, acked, followed by a normal miss -> no dvld_o beat for the flush, and the normal miss data is returned next.
- qrdy_i held low for 10 cycles -> qvld_o and qdat_o stay stable. Spurious ack id 2 while entry 2 is FREE -> err_o=1 stays set and no state changes.
- Reset asserted with 3 entries in WAIT -> the next cycle shows urdy_o=1, qvld_o=0, dvld_o=0; a later ack is flagged as an error.
